// File: rtl/id_ex_stage_reg.sv
// id_ex_stage_reg: ID/EX pipeline register with load-use hazard detection and bubble counter
package lc3b_types;
  typedef enum logic [3:0] {
    op_br = 4'h0, op_add = 4'h1, op_ldb = 4'h2, op_stb = 4'h3,
    op_jsr = 4'h4, op_and = 4'h5, op_ldr = 4'h6, op_str = 4'h7,
    op_rti = 4'h8, op_not = 4'h9, op_ldi = 4'ha, op_sti = 4'hb,
    op_jmp = 4'hc, op_shf = 4'hd, op_lea = 4'he, op_trap = 4'hf
  } lc3b_opcode;
  typedef struct packed {
    lc3b_opcode opcode;
    logic load_dst;
    logic load_cc;
    logic mem_read;
    logic mem_write;
    logic [1:0] alu_op;
  } lc3b_control_word;
endpackage

module id_ex_stage_reg
  import lc3b_types::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [15:0]      id_pc,
  input  logic [15:0]      id_ir,
  input  lc3b_control_word id_ctrl,
  input  logic [15:0]      id_sr1_data,
  input  logic [15:0]      id_sr2_data,
  input  logic [2:0]       id_sr1,
  input  logic [2:0]       id_sr2,
  input  logic             id_uses_sr1,
  input  logic             id_uses_sr2,
  input  logic [2:0]       id_dest,
  input  logic             mem_stall,
  input  logic             flush,
  output logic             ex_valid,
  output logic [15:0]      ex_pc,
  output logic [15:0]      ex_ir,
  output lc3b_control_word ex_ctrl,
  output logic [15:0]      ex_sr1_data,
  output logic [15:0]      ex_sr2_data,
  output logic [2:0]       ex_sr1,
  output logic [2:0]       ex_sr2,
  output logic [2:0]       ex_dest,
  output logic             load_use_stall,
  output logic [CNT_W-1:0] bubble_count
);
  logic ex_is_load, hazard;
  // JSR/TRAP write R7 via load_dst but are not loads, so the opcode filter matters
  assign ex_is_load = ex_valid && ex_ctrl.load_dst &&
                      (ex_ctrl.opcode inside {op_ldr, op_ldb, op_ldi});
  assign hazard = ex_is_load && id_valid &&
                  ((id_uses_sr1 && id_sr1 == ex_dest) || (id_uses_sr2 && id_sr2 == ex_dest));
  assign load_use_stall = hazard && !flush && !reset;
  always_ff @(posedge clk) begin
    if (reset || flush || (!mem_stall && hazard)) begin
      ex_valid    <= 1'b0;
      ex_pc       <= '0;
      ex_ir       <= '0;
      ex_ctrl     <= '0;
      ex_sr1_data <= '0;
      ex_sr2_data <= '0;
      ex_sr1      <= '0;
      ex_sr2      <= '0;
      ex_dest     <= '0;
    end else if (!mem_stall) begin
      ex_valid    <= id_valid;
      ex_pc       <= id_pc;
      ex_ir       <= id_ir;
      ex_ctrl     <= id_valid ? id_ctrl : '0;
      ex_sr1_data <= id_sr1_data;
      ex_sr2_data <= id_sr2_data;
      ex_sr1      <= id_sr1;
      ex_sr2      <= id_sr2;
      ex_dest     <= id_dest;
    end
    if (reset)
      bubble_count <= '0;
    else if (!flush && !mem_stall && hazard)
      bubble_count <= bubble_count + CNT_W'(!(&bubble_count));
  end
endmodule

// File: tb/tb_id_ex_stage_reg.sv
// tb_id_ex_stage_reg: directed checks of capture, load-use bubbles, stall, flush and saturation
module tb_id_ex_stage_reg;
  import lc3b_types::*;
  logic clk = 0;
  always #5 clk = ~clk;
  logic reset, id_valid, id_uses_sr1, id_uses_sr2, mem_stall, flush;
  logic [15:0] id_pc, id_ir, id_sr1_data, id_sr2_data;
  logic [2:0] id_sr1, id_sr2, id_dest;
  lc3b_control_word id_ctrl, ex_ctrl, ex_ctrl2;
  logic ex_valid, load_use_stall, ex_valid2, lus2;
  logic [15:0] ex_pc, ex_ir, ex_sr1_data, ex_sr2_data, ex_pc2, ex_ir2, ex_d1b, ex_d2b;
  logic [2:0] ex_sr1, ex_sr2, ex_dest, ex_s1b, ex_s2b, ex_dst2;
  logic [15:0] bubble_count;
  logic [1:0] bc2;
  int errors = 0, checks = 0;

  id_ex_stage_reg dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc), .id_ir(id_ir),
    .id_ctrl(id_ctrl), .id_sr1_data(id_sr1_data), .id_sr2_data(id_sr2_data),
    .id_sr1(id_sr1), .id_sr2(id_sr2), .id_uses_sr1(id_uses_sr1), .id_uses_sr2(id_uses_sr2),
    .id_dest(id_dest), .mem_stall(mem_stall), .flush(flush), .ex_valid(ex_valid),
    .ex_pc(ex_pc), .ex_ir(ex_ir), .ex_ctrl(ex_ctrl), .ex_sr1_data(ex_sr1_data),
    .ex_sr2_data(ex_sr2_data), .ex_sr1(ex_sr1), .ex_sr2(ex_sr2), .ex_dest(ex_dest),
    .load_use_stall(load_use_stall), .bubble_count(bubble_count));

  id_ex_stage_reg #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc), .id_ir(id_ir),
    .id_ctrl(id_ctrl), .id_sr1_data(id_sr1_data), .id_sr2_data(id_sr2_data),
    .id_sr1(id_sr1), .id_sr2(id_sr2), .id_uses_sr1(id_uses_sr1), .id_uses_sr2(id_uses_sr2),
    .id_dest(id_dest), .mem_stall(mem_stall), .flush(flush), .ex_valid(ex_valid2),
    .ex_pc(ex_pc2), .ex_ir(ex_ir2), .ex_ctrl(ex_ctrl2), .ex_sr1_data(ex_d1b),
    .ex_sr2_data(ex_d2b), .ex_sr1(ex_s1b), .ex_sr2(ex_s2b), .ex_dest(ex_dst2),
    .load_use_stall(lus2), .bubble_count(bc2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_id(input logic v, input lc3b_opcode op, input logic ld, input logic [15:0] pc,
                        input logic [15:0] ir, input logic [2:0] s1, input logic [2:0] s2,
                        input logic u1, input logic u2, input logic [2:0] d);
    id_valid = v; id_ctrl = '0; id_ctrl.opcode = op; id_ctrl.load_dst = ld; id_ctrl.mem_read = 1'b1;
    id_pc = pc; id_ir = ir; id_sr1 = s1; id_sr2 = s2; id_uses_sr1 = u1; id_uses_sr2 = u2;
    id_dest = d; id_sr1_data = {pc[7:0], ir[7:0]}; id_sr2_data = ~ir;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1; mem_stall = 0; flush = 0;
    set_id(1, op_add, 1, 16'h3002, 16'h1644, 1, 4, 1, 1, 3);
    tick(); tick();
    chk("rst_valid", ex_valid, 0);
    chk("rst_ctrl", ex_ctrl, 0);
    chk("rst_count", bubble_count, 0);
    chk("rst_lus", load_use_stall, 0);
    reset = 0;
    tick();
    chk("add_valid", ex_valid, 1);
    chk("add_pc", ex_pc, 16'h3002);
    chk("add_ir", ex_ir, 16'h1644);
    chk("add_dest", ex_dest, 3);
    chk("add_sr1data", ex_sr1_data, 16'h0244);
    // LDR R1,R2,#0 then dependent ADD R3,R1,R4
    set_id(1, op_ldr, 1, 16'h3004, 16'h6280, 2, 0, 1, 0, 1);
    chk("ldr_lus_none", load_use_stall, 0);
    tick();
    chk("ldr_in_ex", ex_ir, 16'h6280);
    set_id(1, op_add, 0, 16'h3006, 16'h1644, 1, 4, 1, 1, 3);
    chk("lu_stall", load_use_stall, 1);
    tick();
    chk("lu_bubble_valid", ex_valid, 0);
    chk("lu_bubble_ctrl", ex_ctrl, 0);
    chk("lu_count", bubble_count, 1);
    chk("lu_stall_clear", load_use_stall, 0);
    tick();
    chk("lu_add_ir", ex_ir, 16'h1644);
    chk("lu_add_valid", ex_valid, 1);
    // immediate ADD whose sr2 field matches must not stall
    set_id(1, op_ldr, 1, 16'h3008, 16'h6280, 2, 0, 1, 0, 1);
    tick();
    set_id(1, op_add, 0, 16'h300a, 16'h1761, 5, 1, 1, 0, 3);
    chk("imm_no_stall", load_use_stall, 0);
    tick();
    chk("imm_ir", ex_ir, 16'h1761);
    chk("imm_count", bubble_count, 1);
    // LEA is not a load
    set_id(1, op_lea, 1, 16'h300c, 16'he201, 0, 0, 0, 0, 1);
    tick();
    set_id(1, op_add, 0, 16'h300e, 16'h1641, 1, 1, 1, 1, 3);
    chk("lea_no_stall", load_use_stall, 0);
    tick();
    chk("lea_add_ir", ex_ir, 16'h1641);
    // JSR writes R7 but is not a load
    set_id(1, op_jsr, 1, 16'h3010, 16'h4800, 0, 0, 0, 0, 7);
    tick();
    set_id(1, op_add, 0, 16'h3012, 16'h1fc7, 7, 7, 1, 1, 7);
    chk("jsr_no_stall", load_use_stall, 0);
    tick();
    // load with load_dst=0 never hazards
    set_id(1, op_ldr, 0, 16'h3014, 16'h6280, 2, 0, 1, 0, 1);
    tick();
    set_id(1, op_add, 0, 16'h3016, 16'h1644, 1, 4, 1, 1, 3);
    chk("noldst_no_stall", load_use_stall, 0);
    tick();
    chk("noldst_count", bubble_count, 1);
    // LDB R2 in EX, dependent STR R2,R3 in ID, memory stalled 3 cycles
    set_id(1, op_ldb, 1, 16'h3018, 16'h2400, 0, 0, 1, 0, 2);
    tick();
    set_id(1, op_str, 0, 16'h301a, 16'h74c0, 3, 2, 1, 1, 0);
    mem_stall = 1;
    #1;
    chk("ms_lus_pre", load_use_stall, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ms_hold_ir", ex_ir, 16'h2400);
      chk("ms_hold_valid", ex_valid, 1);
      chk("ms_lus", load_use_stall, 1);
      chk("ms_count", bubble_count, 1);
    end
    mem_stall = 0;
    tick();
    chk("ms_bubble", ex_valid, 0);
    chk("ms_count_inc", bubble_count, 2);
    tick();
    chk("ms_str_ir", ex_ir, 16'h74c0);
    // flush coincident with hazard
    set_id(1, op_ldr, 1, 16'h301c, 16'h6280, 2, 0, 1, 0, 1);
    tick();
    set_id(1, op_add, 0, 16'h301e, 16'h1644, 1, 4, 1, 1, 3);
    flush = 1;
    #1;
    chk("fl_lus", load_use_stall, 0);
    tick();
    chk("fl_valid", ex_valid, 0);
    chk("fl_ir", ex_ir, 0);
    chk("fl_count", bubble_count, 2);
    flush = 0;
    // id_valid=0 forces ex_ctrl to zero
    set_id(0, op_ldr, 1, 16'h3020, 16'h6280, 2, 0, 1, 0, 1);
    tick();
    chk("inv_valid", ex_valid, 0);
    chk("inv_ctrl", ex_ctrl, 0);
    chk("inv_ir", ex_ir, 16'h6280);
    // two more hazards: narrow counter reaches 3 and then saturates
    for (int i = 0; i < 2; i++) begin
      set_id(1, op_ldi, 1, 16'h3022, 16'ha200, 0, 0, 0, 0, 1);
      tick();
      set_id(1, op_add, 0, 16'h3024, 16'h1644, 1, 4, 1, 1, 3);
      tick();
      chk("sat_count2", bc2, 2'd3);
      chk("sat_count16", bubble_count, 32'(3 + i));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
